// File: rtl/rv32i_pkg.sv
// Shared RV32 definitions for the M-extension sequencer: opcode fields, op and state
// enums, and the final sign-fix/result-select helper.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam int unsigned MD_ITER  = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  // acc holds the 64-bit magnitude product, or {remainder, quotient} for divides.
  function automatic logic [31:0] md_result(md_op_t op, logic [63:0] acc, logic neg_pq,
                                            logic neg_r);
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    prod = neg_pq ? (~acc + 64'd1) : acc;
    quo  = neg_pq ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
    case (op)
      OpMul:                     return prod[31:0];
      OpMulh, OpMulhsu, OpMulhu: return prod[63:32];
      OpDiv, OpDivu:             return quo;
      default:                   return rem;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_md_step.sv
// One iteration of the multi-cycle datapath: radix-2 shift-add multiply or
// restoring shift-subtract divide on a 64-bit accumulator.
module rv32i_md_step (
  input  logic        div_mode,
  input  logic [63:0] acc,
  input  logic [31:0] opb,
  output logic [63:0] acc_next,
  output logic        q_bit
);

  logic [32:0] sum;
  logic [32:0] diff;

  always_comb begin
    sum      = {1'b0, acc[63:32]} + {1'b0, opb};
    diff     = acc[63:31] - {1'b0, opb};
    acc_next = '0;
    q_bit    = 1'b0;
    if (div_mode) begin
      // No borrow means the shifted partial remainder covers the divisor.
      q_bit    = ~diff[32];
      acc_next = {(q_bit ? diff[31:0] : acc[62:31]), acc[30:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[31:1]};
    end else begin
      acc_next = {1'b0, acc[63:1]};
    end
  end

endmodule

// File: rtl/rv32i_md_seq.sv
// RV32M multiply/divide sequencer beside the execute ALU. Define RV32M_FAST_MUL_EN
// to compute multiplies in one cycle with a 33x33 signed multiplier.
module rv32i_md_seq
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = MD_ITER
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [4:0]      wb_reg_in,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] md_out,
  output logic [4:0]      wb_reg_out,
  output logic            wb_en_out
);

  localparam int unsigned CntW = $clog2(ITER);

  md_state_t       state_q;
  md_op_t          op_q;
  logic [CntW-1:0] cnt_q;
  logic [63:0]     acc_q;
  logic [31:0]     opb_q;
  logic            neg_pq_q;
  logic            neg_r_q;
  logic [4:0]      wb_q;

  md_op_t      op_in;
  logic        is_div;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        div_zero;
  logic        div_ovf;
  logic        imm_hit;
  logic [31:0] imm_res;

  logic [63:0] step_acc;
  logic        step_q;
  logic [63:0] acc_d;

`ifdef RV32M_FAST_MUL_EN
  logic signed [32:0] fast_a;
  logic signed [32:0] fast_b;
  logic signed [65:0] fast_p;
  assign fast_a = {((op_in == OpMulh || op_in == OpMulhsu) && rs1_data_in[31]), rs1_data_in};
  assign fast_b = {(op_in == OpMulh && rs2_data_in[31]), rs2_data_in};
  assign fast_p = fast_a * fast_b;
`endif

  always_comb begin
    op_in    = md_op_t'(func3);
    is_div   = func3[2];
    sign_a   = (op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem}) && rs1_data_in[31];
    sign_b   = (op_in inside {OpMulh, OpDiv, OpRem}) && rs2_data_in[31];
    abs_a    = sign_a ? (~rs1_data_in + 32'd1) : rs1_data_in;
    abs_b    = sign_b ? (~rs2_data_in + 32'd1) : rs2_data_in;
    div_zero = is_div && (rs2_data_in == '0);
    div_ovf  = (op_in inside {OpDiv, OpRem}) && (rs1_data_in == 32'h8000_0000) &&
               (rs2_data_in == 32'hFFFF_FFFF);
    imm_hit  = div_zero || div_ovf;
    // func3[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) imm_res = func3[1] ? rs1_data_in : 32'hFFFF_FFFF;
    else          imm_res = func3[1] ? 32'd0 : 32'h8000_0000;
`ifdef RV32M_FAST_MUL_EN
    if (!is_div) begin
      imm_hit = 1'b1;
      imm_res = (op_in == OpMul) ? fast_p[31:0] : fast_p[63:32];
    end
`endif
  end

  rv32i_md_step u_step (
    .div_mode (op_q[2]),
    .acc      (acc_q),
    .opb      (opb_q),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // The quotient bit shifts into the LSB vacated by the step.
  assign acc_d = {step_acc[63:1], step_acc[0] | step_q};

  assign stall = ((state_q == IDLE) && start && !kill) || (state_q == BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OpMul;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      neg_pq_q   <= 1'b0;
      neg_r_q    <= 1'b0;
      wb_q       <= '0;
      done       <= 1'b0;
      md_out     <= '0;
      wb_reg_out <= '0;
      wb_en_out  <= 1'b0;
    end else if (kill) begin
      state_q   <= IDLE;
      done      <= 1'b0;
      wb_en_out <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done      <= 1'b0;
          wb_en_out <= 1'b0;
          if (start) begin
            op_q     <= op_in;
            wb_q     <= wb_reg_in;
            neg_pq_q <= sign_a ^ sign_b;
            neg_r_q  <= sign_a;
            acc_q    <= {32'd0, abs_a};
            opb_q    <= abs_b;
            cnt_q    <= CntW'(ITER - 1);
            if (imm_hit) begin
              state_q    <= DONE;
              done       <= 1'b1;
              md_out     <= imm_res;
              wb_reg_out <= wb_reg_in;
              wb_en_out  <= |wb_reg_in;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            state_q    <= DONE;
            done       <= 1'b1;
            md_out     <= md_result(op_q, acc_d, neg_pq_q, neg_r_q);
            wb_reg_out <= wb_q;
            wb_en_out  <= |wb_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          done      <= 1'b0;
          wb_en_out <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_md_seq.sv
// Self-checking bench for rv32i_md_seq: directed vector table, kill/reset sequences and
// randomized operations checked against an arithmetic reference model.
module tb_rv32i_md_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        kill;
  logic [2:0]  func3;
  logic [31:0] rs1_data_in;
  logic [31:0] rs2_data_in;
  logic [4:0]  wb_reg_in;
  logic        stall;
  logic        done;
  logic [31:0] md_out;
  logic [4:0]  wb_reg_out;
  logic        wb_en_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_md_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .kill        (kill),
    .func3       (func3),
    .rs1_data_in (rs1_data_in),
    .rs2_data_in (rs2_data_in),
    .wb_reg_in   (wb_reg_in),
    .stall       (stall),
    .done        (done),
    .md_out      (md_out),
    .wb_reg_out  (wb_reg_out),
    .wb_en_out   (wb_en_out)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit and signed integer arithmetic.
  function automatic logic [31:0] ref_md(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    ua = {32'd0, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    if (f[2]) begin
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef RV32M_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge after the done cycle.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wb, input logic [31:0] exp);
    int lat_exp;
    int n;
    int stalls;
    lat_exp     = exp_latency(f, a, b);
    func3       = f;
    rs1_data_in = a;
    rs2_data_in = b;
    wb_reg_in   = wb;
    start       = 1'b1;
    #1;
    stalls = stall ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    n     = 1;
    while (!done && n <= 100) begin
      if (stall) stalls++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s/timeout: no done after %0d cycles, required within %0d", name, n,
               lat_exp);
      return;
    end
    chk({name, "/result"}, md_out, exp);
    chk({name, "/latency"}, n, lat_exp);
    chk({name, "/stall_cycles"}, stalls, lat_exp);
    chk({name, "/stall_at_done"}, {31'd0, stall}, 32'd0);
    chk({name, "/wb_reg_out"}, {27'd0, wb_reg_out}, {27'd0, wb});
    chk({name, "/wb_en_out"}, {31'd0, wb_en_out}, {31'd0, (wb != 5'd0)});
    @(negedge clk);
    chk({name, "/done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  // Abort a DIV at T+10 with kill or reset, then run a DIVU from T+12.
  task automatic abort_seq(input string name, input bit use_reset);
    int n;
    func3       = 3'd4;
    rs1_data_in = 32'hFFFF_FFF9;
    rs2_data_in = 32'd2;
    wb_reg_in   = 5'd9;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 1;
    while (n < 10) begin
      if (done) begin
        checks++;
        errors++;
        $display("FAIL %s/early_done: done=1 at T+%0d, required 0", name, n);
      end
      @(negedge clk);
      n++;
    end
    if (use_reset) reset = 1'b1;
    else kill = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    kill  = 1'b0;
    chk({name, "/done_after"}, {31'd0, done}, 32'd0);
    chk({name, "/stall_after"}, {31'd0, stall}, 32'd0);
    chk({name, "/wb_en_after"}, {31'd0, wb_en_out}, 32'd0);
    if (use_reset) begin
      chk({name, "/md_out_after"}, md_out, 32'd0);
      chk({name, "/wb_reg_after"}, {27'd0, wb_reg_out}, 32'd0);
    end
    @(negedge clk);
    run_op({name, "/restart"}, 3'd5, 32'd100, 32'd7, 5'd12, 32'd14);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         5'd11, 32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0};
    vecs[12] = '{3'd0, 32'd6,         32'd7,         5'd15, 32'd42};
    vecs[13] = '{3'd4, 32'h8000_0000, 32'd1,         5'd16, 32'h8000_0000};
    vecs[14] = '{3'd7, 32'hFFFF_FFFF, 32'd0,         5'd17, 32'hFFFF_FFFF};
    vecs[15] = '{3'd3, 32'h8000_0000, 32'd2,         5'd0,  32'd1};
    vecs[16] = '{3'd4, 32'hFFFF_FFFF, 32'd0,         5'd0,  32'hFFFF_FFFF};
    vecs[17] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};

    reset       = 1'b1;
    start       = 1'b0;
    kill        = 1'b0;
    func3       = 3'd0;
    rs1_data_in = '0;
    rs2_data_in = '0;
    wb_reg_in   = '0;
    repeat (3) @(negedge clk);
    chk("reset/stall", {31'd0, stall}, 32'd0);
    chk("reset/done", {31'd0, done}, 32'd0);
    chk("reset/md_out", md_out, 32'd0);
    chk("reset/wb_reg_out", {27'd0, wb_reg_out}, 32'd0);
    chk("reset/wb_en_out", {31'd0, wb_en_out}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].wb,
             vecs[i].exp);
    end

    abort_seq("kill", 1'b0);
    abort_seq("reset", 1'b1);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  wb;
      f  = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      wb = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d_f%0d_%h_%h", i, f, a, b), f, a, b, wb, ref_md(f, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
